rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction-ROM read port between two requesters: the core instruction-fetch port (IF) and a data-bus read port (D), which serves constant/table loads from ROM space.
- Registers the ROM output, so every grant returns data exactly one cycle later.
- Uses fixed priority with a starvation guard, and flags misaligned or out-of-range accesses.
- Sits between the core/bus interconnect and the ROM instance.

Parameters:
- ADDR_W, 12, byte-address width of both request ports and rom_addr
- DATA_W, 32, ROM word width
- DEPTH, 128, number of ROM words; valid byte range is 0 .. DEPTH*4-1
- MAX_WAIT, 3, consecutive cycles IF may be denied before it is forced to win (1..15)
- NOP_WORD, 32'h00000013, word returned to IF on an error access

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- if_req  in  1  IF read request, level, held until granted
- if_addr  in  ADDR_W  IF byte address
- if_gnt  out  1  IF request accepted this cycle (combinational)
- if_rvalid  out  1  IF read data valid (registered)
- if_rdata  out  DATA_W  IF read data
- if_err  out  1  qualifies if_rvalid: misaligned or out-of-range access
- d_req  in  1  D read request, level, held until granted
- d_addr  in  ADDR_W  D byte address
- d_gnt  out  1  D request accepted this cycle (combinational)
- d_rvalid  out  1  D read data valid (registered)
- d_rdata  out  DATA_W  D read data
- d_err  out  1  qualifies d_rvalid: misaligned or out-of-range access
- rom_addr  out  ADDR_W  address driven to the ROM (byte address)
- rom_inst  in  DATA_W  combinational ROM output for rom_addr

Behaviour:
- Reset (synchronous, reset_n=0 at a clk edge):
  - if_rvalid, d_rvalid, if_err, d_err = 0
  - if_rdata, d_rdata = 0
  - wait counter = 0, owner register = IF
  - gnt outputs are 0 while reset_n=0
- Arbitration, combinational each cycle:
  - Only one requester: it is granted.
  - Both requesting: D wins, unless wait_cnt == MAX_WAIT; then IF wins.
  - Neither requesting: no grant. rom_addr holds the last granted address, so the ROM input is not toggled.
- rom_addr = granted requester's address (if_addr or d_addr), else the held value.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) each cycle if_req=1 and if_gnt=0.
  - Clears on if_gnt or when if_req=0.
- Response, one cycle after grant:
  - Registers rom_inst into the granted port's rdata.
  - Pulses that port's rvalid for exactly 1 cycle.
  - The other port's rvalid is 0 that cycle.
  - rdata holds its last value when rvalid=0.
- Back-to-back:
  - A port may be granted on consecutive cycles, giving rvalid on consecutive cycles (throughput 1 word/cycle total).
- Error checks, evaluated at grant:
  - misaligned = addr[1:0] != 0
  - out_of_range = (addr >> 2) >= DEPTH
- Error response: on either condition, the data phase sets err=1 with rvalid=1.
  - rdata = NOP_WORD for IF.
  - rdata = 0 for D.
  - The ROM is not read: rom_addr keeps its held value.
- The word index is addr[ADDR_W-1:2]. The low two bits never reach the ROM word select.
- Simultaneous request and response: a new grant in the same cycle that a previous rvalid is high is legal.
- Reset mid-transfer: a grant outstanding at reset is dropped, with no rvalid afterwards. Requesters must re-issue their request.
- Requests are not queued. A request withdrawn before grant is not served, and there is no error for it.

Decomposition:
- Shared package rom_arb_pkg:
  - typedef owner_e {OWN_IF, OWN_D}
  - NOP_WORD constant
  - function addr_err(addr, depth) returning {misaligned, out_of_range}
- One natural sub-module: rom_arb_starve_cnt (saturating wait counter plus force flag).
- The data-phase register and the muxing stay in the top module.

Test Plan:
- IF only, if_addr=0x008, ROM[2]=0x10058593 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x10058593, if_err=0, d_rvalid=0.
- Both requesting continuously, MAX_WAIT=3 -> grant sequence D,D,D,IF,D,D,D,IF…; wait_cnt never exceeds 3; every granted cycle yields exactly one rvalid next cycle.
- d_addr=0x006 (misaligned) -> d_rvalid=1, d_err=1, d_rdata=0; rom_addr unchanged from the prior value.
- if_addr=0x200 with DEPTH=128 -> if_rvalid=1, if_err=1, if_rdata=0x00000013.
- Alternate IF at 0x000 and D at 0x004 on single-requester cycles, back-to-back -> rvalid pulses on alternating ports on consecutive cycles, with data matching ROM[0] and ROM[1].
- Grant D at cycle N, reset_n=0 at cycle N+1 -> d_rvalid stays 0, all outputs 0 during reset, wait_cnt=0 after release.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the instruction-ROM port arbiter.
// Owner encoding, the IF error word and the address checker.
package rom_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // {misaligned, out_of_range} for a byte address against a word depth
  function automatic logic [1:0] addr_err(
    input logic [31:0] addr,
    input logic [31:0] depth
  );
    logic mis;
    logic oor;
    mis = (addr[1:0] != 2'b00);
    oor = ((addr >> 2) >= depth);
    return {mis, oor};
  endfunction

endpackage

// File: rtl/rom_arb_starve_cnt.sv
// Counts consecutive cycles IF waits while requesting.
// Raises force_if once the wait reaches MAX_WAIT.
module rom_arb_starve_cnt #(
  parameter int MAX_WAIT = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic if_req,
  input  logic if_gnt,
  output logic force_if
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // saturating count of denied IF cycles, cleared on grant or idle
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = 4'd0;
    end else if (cnt_q < 4'(MAX_WAIT)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == 4'(MAX_WAIT));

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one combinational ROM read port between IF and D.
// Fixed D priority with an IF starvation guard; registered data.
module rom_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH = 128,
  parameter int MAX_WAIT = 3,
  parameter logic [DATA_W-1:0] NOP_WORD =
    DATA_W'(rom_arb_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);
  import rom_arb_pkg::*;

  logic              force_if;
  logic              if_bad;
  logic              d_bad;
  logic              any_gnt;
  logic              sel_bad;
  logic [ADDR_W-1:0] sel_addr;

  logic              pend_q, pend_d;
  logic              err_q, err_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  rom_arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .force_if(force_if)
  );

  // address checks, grant decision and ROM address mux
  always_comb begin
    if_bad   = |addr_err(32'(if_addr), 32'(DEPTH));
    d_bad    = |addr_err(32'(d_addr), 32'(DEPTH));
    if_gnt   = reset_n & if_req & (~d_req | force_if);
    d_gnt    = reset_n & d_req & ~if_gnt;
    any_gnt  = if_gnt | d_gnt;
    sel_addr = if_gnt ? if_addr : d_addr;
    sel_bad  = if_gnt ? if_bad : d_bad;
    rom_addr = rom_addr_q;
    if (any_gnt && !sel_bad) begin
      rom_addr = sel_addr;
    end
  end

  // data-phase next state captured at grant
  always_comb begin
    rom_addr_d = rom_addr;
    pend_d     = any_gnt;
    err_d      = any_gnt & sel_bad;
    owner_d    = owner_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (if_gnt) begin
      owner_d    = OWN_IF;
      if_rdata_d = if_bad ? NOP_WORD : rom_inst;
    end else if (d_gnt) begin
      owner_d   = OWN_D;
      d_rdata_d = d_bad ? '0 : rom_inst;
    end
  end

  // data-phase registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      owner_q    <= OWN_IF;
      rom_addr_q <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      pend_q     <= pend_d;
      err_q      <= err_d;
      owner_q    <= owner_d;
      rom_addr_q <= rom_addr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // response outputs, forced quiet while reset is held
  always_comb begin
    if_rvalid = reset_n & pend_q & (owner_q == OWN_IF);
    d_rvalid  = reset_n & pend_q & (owner_q == OWN_D);
    if_err    = if_rvalid & err_q;
    d_err     = d_rvalid & err_q;
    if_rdata  = reset_n ? if_rdata_q : '0;
    d_rdata   = reset_n ? d_rdata_q : '0;
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter.
// ROM model: word i = {16'hC0DE, i}, except word 2 = 32'h10058593.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, d_req;
  logic [11:0] if_addr, d_addr;
  logic        if_gnt, d_gnt;
  logic        if_rvalid, d_rvalid;
  logic [31:0] if_rdata, d_rdata;
  logic        if_err, d_err;
  logic [11:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] rom [0:1023];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rom_inst = rom[rom_addr[11:2]];

  rom_port_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .rom_addr (rom_addr),
    .rom_inst (rom_inst)
  );

  task automatic test_reset();
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 12'h000;
    d_req = 1'b1; d_addr = 12'h004;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({if_gnt, d_gnt} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_gnt got=%b exp=00", {if_gnt, d_gnt});
    end
    n_chk++;
    if ({if_rvalid, d_rvalid, if_err, d_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=0000",
               {if_rvalid, d_rvalid, if_err, d_err});
    end
    n_chk++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata});
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_only();
    if_req = 1'b1; if_addr = 12'h008;
    #1;
    n_chk++;
    if ({if_gnt, d_gnt, rom_addr} !== {2'b10, 12'h008}) begin
      n_fail++;
      $display("FAIL if_only_gnt got=%b/%h exp=10/008",
               {if_gnt, d_gnt}, rom_addr);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n_chk++;
    if ({if_rvalid, if_err, d_rvalid} !== 3'b100 ||
        if_rdata !== 32'h10058593) begin
      n_fail++;
      $display("FAIL if_only_rsp got=%b/%h exp=100/10058593",
               {if_rvalid, if_err, d_rvalid}, if_rdata);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h10058593) begin
      n_fail++;
      $display("FAIL if_only_hold got=%b/%h exp=0/10058593",
               if_rvalid, if_rdata);
    end
  endtask

  task automatic test_priority();
    logic prev_if;
    prev_if = 1'b0;
    if_addr = 12'h00C; d_addr = 12'h010;
    for (int i = 0; i < 8; i++) begin
      logic exp_if;
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      exp_if = ((i % 4) == 3);
      #1;
      n_chk++;
      if ({if_gnt, d_gnt} !== {exp_if, ~exp_if}) begin
        n_fail++;
        $display("FAIL prio_gnt[%0d] got=%b exp=%b", i,
                 {if_gnt, d_gnt}, {exp_if, ~exp_if});
      end
      if (i > 0) begin
        n_chk++;
        if ({if_rvalid, d_rvalid} !== {prev_if, ~prev_if}) begin
          n_fail++;
          $display("FAIL prio_rvalid[%0d] got=%b exp=%b", i,
                   {if_rvalid, d_rvalid}, {prev_if, ~prev_if});
        end
      end
      prev_if = exp_if;
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    #1;
    n_chk++;
    if ({if_rvalid, d_rvalid} !== 2'b10 ||
        if_rdata !== 32'hC0DE0003 || d_rdata !== 32'hC0DE0004) begin
      n_fail++;
      $display("FAIL prio_data got=%b/%h/%h exp=10/c0de0003/c0de0004",
               {if_rvalid, d_rvalid}, if_rdata, d_rdata);
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    d_req = 1'b1; d_addr = 12'h014;
    #1;
    n_chk++;
    if (d_gnt !== 1'b1 || rom_addr !== 12'h014) begin
      n_fail++;
      $display("FAIL mis_setup got=%b/%h exp=1/014", d_gnt, rom_addr);
    end
    @(negedge clk);
    d_addr = 12'h006;
    #1;
    n_chk++;
    if (d_gnt !== 1'b1 || rom_addr !== 12'h014) begin
      n_fail++;
      $display("FAIL mis_romaddr got=%b/%h exp=1/014", d_gnt, rom_addr);
    end
    n_chk++;
    if ({d_rvalid, d_err} !== 2'b10 || d_rdata !== 32'hC0DE0005) begin
      n_fail++;
      $display("FAIL mis_prev got=%b/%h exp=10/c0de0005",
               {d_rvalid, d_err}, d_rdata);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    n_chk++;
    if ({d_rvalid, d_err, if_rvalid} !== 3'b110 ||
        d_rdata !== 32'h0 || rom_addr !== 12'h014) begin
      n_fail++;
      $display("FAIL mis_rsp got=%b/%h/%h exp=110/00000000/014",
               {d_rvalid, d_err, if_rvalid}, d_rdata, rom_addr);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    if_req = 1'b1; if_addr = 12'h200;
    #1;
    n_chk++;
    if (if_gnt !== 1'b1 || rom_addr !== 12'h014) begin
      n_fail++;
      $display("FAIL oor_gnt got=%b/%h exp=1/014", if_gnt, rom_addr);
    end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    n_chk++;
    if ({if_rvalid, if_err, d_rvalid} !== 3'b110 ||
        if_rdata !== 32'h00000013) begin
      n_fail++;
      $display("FAIL oor_rsp got=%b/%h exp=110/00000013",
               {if_rvalid, if_err, d_rvalid}, if_rdata);
    end
  endtask

  task automatic test_back_to_back();
    if_addr = 12'h000; d_addr = 12'h004;
    for (int i = 0; i < 4; i++) begin
      logic use_if;
      @(negedge clk);
      use_if = ((i % 2) == 0);
      if_req = use_if; d_req = ~use_if;
      #1;
      n_chk++;
      if ({if_gnt, d_gnt} !== {use_if, ~use_if}) begin
        n_fail++;
        $display("FAIL b2b_gnt[%0d] got=%b exp=%b", i,
                 {if_gnt, d_gnt}, {use_if, ~use_if});
      end
      if (i == 2) begin
        n_chk++;
        if ({if_rvalid, d_rvalid, d_err} !== 3'b010 ||
            d_rdata !== 32'hC0DE0001) begin
          n_fail++;
          $display("FAIL b2b_d got=%b/%h exp=010/c0de0001",
                   {if_rvalid, d_rvalid, d_err}, d_rdata);
        end
      end
      if (i == 3) begin
        n_chk++;
        if ({if_rvalid, d_rvalid, if_err} !== 3'b100 ||
            if_rdata !== 32'hC0DE0000) begin
          n_fail++;
          $display("FAIL b2b_if got=%b/%h exp=100/c0de0000",
                   {if_rvalid, d_rvalid, if_err}, if_rdata);
        end
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    #1;
    n_chk++;
    if ({if_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'hC0DE0001) begin
      n_fail++;
      $display("FAIL b2b_last got=%b/%h exp=01/c0de0001",
               {if_rvalid, d_rvalid}, d_rdata);
    end
  endtask

  task automatic test_reset_mid();
    if_addr = 12'h00C; d_addr = 12'h010;
    repeat (2) begin
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      n_chk++;
      if ({if_gnt, d_gnt} !== 2'b01) begin
        n_fail++;
        $display("FAIL rmid_pre got=%b exp=01", {if_gnt, d_gnt});
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({d_rvalid, if_gnt, d_gnt} !== 3'b000) begin
      n_fail++;
      $display("FAIL rmid_drop got=%b exp=000",
               {d_rvalid, if_gnt, d_gnt});
    end
    @(negedge clk);
    #1;
    n_chk++;
    if ({if_rvalid, d_rvalid, if_err, d_err, if_gnt, d_gnt} !== 6'b0 ||
        {if_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL rmid_outs got=%b/%h exp=0/0",
               {if_rvalid, d_rvalid, if_err, d_err, if_gnt, d_gnt},
               {if_rdata, d_rdata});
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_if;
      if (i > 0) @(negedge clk);
      exp_if = (i == 3);
      #1;
      n_chk++;
      if ({if_gnt, d_gnt} !== {exp_if, ~exp_if}) begin
        n_fail++;
        $display("FAIL rmid_seq[%0d] got=%b exp=%b", i,
                 {if_gnt, d_gnt}, {exp_if, ~exp_if});
      end
      if (i == 0) begin
        n_chk++;
        if ({if_rvalid, d_rvalid} !== 2'b00) begin
          n_fail++;
          $display("FAIL rmid_stale got=%b exp=00",
                   {if_rvalid, d_rvalid});
        end
      end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom[i] = {16'hC0DE, 16'(i)};
    end
    rom[2] = 32'h10058593;
    reset_n = 1'b0;
    if_req = 1'b0; d_req = 1'b0;
    if_addr = '0; d_addr = '0;
    @(negedge clk);
    test_reset();
    test_if_only();
    test_priority();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
